// File: rtl/inst_mem_fetch_if.sv
// inst_mem_fetch_if -- loader and fetch bus between the front end and the
// instruction memory.
//   master : loader + PC side (drives load_*, fetch_req/addr, flush, resp_ready)
//   slave  : instruction memory (drives load_err, run, fetch_ready, resp_*, fault)
// Loader port : load_en, load_addr, load_data, load_done, load_err
// Fetch port  : fetch_req, fetch_addr, fetch_ready, flush
// Response    : resp_valid, resp_ready, fetch_instr, fault
interface inst_mem_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              load_err;
  logic              run;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] fetch_instr;
  logic [1:0]        fault;

  modport master (
    output load_en, load_addr, load_data, load_done,
    output fetch_req, fetch_addr, flush, resp_ready,
    input  load_err, run, fetch_ready, resp_valid, fetch_instr, fault
  );

  modport slave (
    input  load_en, load_addr, load_data, load_done,
    input  fetch_req, fetch_addr, flush, resp_ready,
    output load_err, run, fetch_ready, resp_valid, fetch_instr, fault
  );
endinterface

// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch -- synchronous byte-addressed instruction memory for the IFU.
// A LOAD/RUN FSM gates a word-wide loader (LOAD) against a valid/ready fetch
// port (RUN). Fetch responses carry a fault code: 0 ok, 1 misaligned,
// 2 out of range; faulted fetches return FAULT_INSTR and do not read memory.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset (state -> LOAD, responses dropped,
//           memory contents kept)
//   bus   : inst_mem_fetch_if.slave (loader, fetch request, response)
// Build option:
//   INST_MEM_OUT_REG_EN -- adds an output register stage (fetch latency 2,
//   two-slot pipeline). Undefined: single stage, fetch latency 1.
module inst_mem_fetch #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH_WORDS = 64,
  parameter logic [DATA_W-1:0] FAULT_INSTR = '0
) (
  input logic            clk,
  input logic            reset,
  inst_mem_fetch_if.slave bus
);

  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Byte-offset bits inside a word; zero when DATA_W is a single byte.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t state_reg, state_next;
  logic   load_err_reg, load_err_next;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_data_reg;

  logic [1:0]        load_fault, fetch_fault;
  logic [IDX_W-1:0]  load_idx, fetch_idx;
  logic              load_wr, accept, rd_en, run;

  // Misaligned wins over out-of-range.
  function automatic logic [1:0] decode_fault(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] widx;
    logic [1:0]        f;
    widx = addr >> OFF;
    f    = 2'd0;
    if ((addr & LOW_MASK) != '0)
      f = 2'd1;
    else if (widx >= ADDR_W'(DEPTH_WORDS))
      f = 2'd2;
    return f;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] widx;
    widx = addr >> OFF;
    return widx[IDX_W-1:0];
  endfunction

  assign load_fault  = decode_fault(bus.load_addr);
  assign fetch_fault = decode_fault(bus.fetch_addr);
  assign load_idx    = word_idx(bus.load_addr);
  assign fetch_idx   = word_idx(bus.fetch_addr);

  assign run     = (state_reg == ST_RUN);
  assign load_wr = (state_reg == ST_LOAD) & bus.load_en & (load_fault == 2'd0);
  assign accept  = bus.fetch_req & bus.fetch_ready;
  assign rd_en   = accept & (fetch_fault == 2'd0);

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_LOAD;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_err_reg <= load_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    load_err_next = load_err_reg;
    case (state_reg)
      ST_LOAD: begin
        if (bus.load_en && (load_fault != 2'd0))
          load_err_next = 1'b1;
        if (bus.load_done)
          state_next = ST_RUN;
      end
      ST_RUN: state_next = ST_RUN;
      default: state_next = ST_LOAD;
    endcase
  end

  // ---------------- storage (no reset so it maps onto block RAM) ----------------
  always_ff @(posedge clk) begin
    if (load_wr)
      mem[load_idx] <= bus.load_data;
  end

  // Read register only advances on a non-faulting accept, so it holds the
  // presented word for as long as the response stalls.
  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data_reg <= mem[fetch_idx];
  end

`ifdef INST_MEM_OUT_REG_EN
  // Slot 1 holds the BRAM read, slot 2 is the output register.
  logic              s1_valid_reg, s2_valid_reg;
  logic [1:0]        s1_fault_reg, s2_fault_reg;
  logic [DATA_W-1:0] s2_instr_reg;
  logic              s2_take, s1_free;

  assign s2_take = ~s2_valid_reg | bus.resp_ready;
  assign s1_free = ~s1_valid_reg | s2_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_fault_reg <= 2'd0;
      s2_valid_reg <= 1'b0;
      s2_fault_reg <= 2'd0;
      s2_instr_reg <= '0;
    end else if (bus.flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_take) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_fault_reg <= s1_fault_reg;
          s2_instr_reg <= (s1_fault_reg != 2'd0) ? FAULT_INSTR : rd_data_reg;
        end
      end
      if (s1_free) begin
        s1_valid_reg <= accept;
        if (accept)
          s1_fault_reg <= fetch_fault;
      end
    end
  end

  assign bus.fetch_ready = run & ~bus.flush & s1_free;
  assign bus.resp_valid  = s2_valid_reg;
  assign bus.fault       = s2_valid_reg ? s2_fault_reg : 2'd0;
  assign bus.fetch_instr = s2_valid_reg ? s2_instr_reg : '0;
`else
  logic       resp_valid_reg;
  logic [1:0] fault_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_reg <= 1'b0;
      fault_reg      <= 2'd0;
    end else if (bus.flush) begin
      resp_valid_reg <= 1'b0;
    end else if (accept) begin
      resp_valid_reg <= 1'b1;
      fault_reg      <= fetch_fault;
    end else if (bus.resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign bus.fetch_ready = run & ~bus.flush & (~resp_valid_reg | bus.resp_ready);
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.fault       = resp_valid_reg ? fault_reg : 2'd0;
  // Idle output reads as zero so a stale word never leaks after reset/flush.
  assign bus.fetch_instr = !resp_valid_reg      ? '0 :
                           (fault_reg != 2'd0)  ? FAULT_INSTR : rd_data_reg;
`endif

  assign bus.run      = run;
  assign bus.load_err = load_err_reg;

endmodule
